// File: rtl/outport_uart_tx.sv
// outport_uart_tx: captures OUTPORTout changes into a FIFO and sends each word as 8N1 UART bytes, MSB byte first (OUTPORT_UART_NEWLINE_EN appends a 0x0A frame per word)
module outport_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] OUTPORTout,
  input  logic        run,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
`ifdef OUTPORT_UART_NEWLINE_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state, state_n;
  logic [31:0]   last_val, shift_word, shift_word_n;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic [15:0]   div_cnt, div_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n, byte_idx, byte_idx_n;
  logic [7:0]    cur_byte, cur_byte_n, load_byte;
  logic          tx_n, busy_n, push, pop, full, empty, wr_en, div_end;
  assign empty   = count == '0;
  assign full    = count == DEPTH_C;
  assign push    = run && (OUTPORTout != last_val);
  assign wr_en   = push && (!full || pop);
  assign count_n = (wr_en && !pop) ? count + 1'b1 : (!wr_en && pop) ? count - 1'b1 : count;
  assign busy_n  = (count_n != '0) || (state_n != IDLE);
  assign div_end = div_cnt == DIV_MAX;
`ifdef OUTPORT_UART_NEWLINE_EN
  assign load_byte = (byte_idx == LAST_BYTE) ? 8'h0A : shift_word[31:24];
`else
  assign load_byte = shift_word[31:24];
`endif
  // Next-state logic: frame sequencing, bit shifting, and FIFO pop at word boundaries
  always_comb begin
    state_n      = state;
    div_cnt_n    = (state == IDLE || div_end) ? '0 : div_cnt + 16'd1;
    bit_idx_n    = bit_idx;
    byte_idx_n   = byte_idx;
    cur_byte_n   = cur_byte;
    shift_word_n = shift_word;
    tx_n         = tx;
    pop          = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop          = 1'b1;
        shift_word_n = mem[rd_ptr];
        byte_idx_n   = '0;
        state_n      = START;
        tx_n         = 1'b0;
      end
      START: if (div_end) begin
        state_n      = DATA;
        bit_idx_n    = '0;
        tx_n         = load_byte[0];
        cur_byte_n   = {1'b0, load_byte[7:1]};
        shift_word_n = {shift_word[23:0], 8'h00};
      end
      DATA: if (div_end) begin
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_idx_n  = bit_idx + 3'd1;
          tx_n       = cur_byte[0];
          cur_byte_n = {1'b0, cur_byte[7:1]};
        end
      end
      STOP: if (div_end) begin
        if (byte_idx != LAST_BYTE) begin
          byte_idx_n = byte_idx + 3'd1;
          state_n    = START;
          tx_n       = 1'b0;
        end else if (!empty) begin
          pop          = 1'b1;
          shift_word_n = mem[rd_ptr];
          byte_idx_n   = '0;
          state_n      = START;
          tx_n         = 1'b0;
        end else begin
          state_n = IDLE;
          tx_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // State, counters, change detector and FIFO pointers; reset abandons any frame and flushes the FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      cur_byte   <= '0;
      shift_word <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      last_val   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state      <= state_n;
      div_cnt    <= div_cnt_n;
      bit_idx    <= bit_idx_n;
      byte_idx   <= byte_idx_n;
      cur_byte   <= cur_byte_n;
      shift_word <= shift_word_n;
      tx         <= tx_n;
      busy       <= busy_n;
      overflow   <= overflow | (push && full && !pop);
      last_val   <= push ? OUTPORTout : last_val;
      wr_ptr     <= wr_en ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count      <= count_n;
    end
  end
  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= OUTPORTout;
  end
endmodule

// File: tb/tb_outport_uart_tx.sv
// tb_outport_uart_tx: scoreboard bench decoding the UART line against words captured from OUTPORTout
module tb_outport_uart_tx;
  localparam int CLK_DIV = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef OUTPORT_UART_NEWLINE_EN
  localparam int BPW = 5;
`else
  localparam int BPW = 4;
`endif
  localparam int WORD_CYC = 10 * CLK_DIV * BPW;
  logic clk = 0, reset = 0, run = 1;
  logic [31:0] OUTPORTout = 32'hFFFF_FFFF;
  logic tx, busy, overflow;
  int chk_cnt = 0, pass_cnt = 0, rx_cnt = 0, cyc = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  logic [7:0] mon_b, mon_e;
  bit mon_abort;
  typedef struct {
    bit run;
    logic [31:0] val;
    bit send;
  } vec_t;
  vec_t tv[10];

  outport_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .OUTPORTout(OUTPORTout), .run(run),
    .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic push_word(input logic [31:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[31-8*i -: 8]);
`ifdef OUTPORT_UART_NEWLINE_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
    repeat (8) @(negedge clk);
  endtask

  // UART receiver: samples mid-bit on falling clock edges, aborts a frame if reset asserts
  always begin
    @(negedge clk);
    if (reset === 1'b1 && tx === 1'b0) begin
      start_q.push_back(cyc);
      mon_abort = 0;
      repeat (2) @(negedge clk);
      if (!reset) mon_abort = 1;
      else check("start_bit", tx, 0);
      for (int i = 0; i < 9 && !mon_abort; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        if (!reset) mon_abort = 1;
        else if (i < 8) mon_b[i] = tx;
      end
      if (!mon_abort) begin
        check("stop_bit", tx, 1);
        rx_cnt++;
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_byte: got %h expected none", mon_b);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_byte", mon_b, mon_e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    tv[0] = '{1'b1, 32'h1234_5678, 1'b1};
    tv[1] = '{1'b1, 32'h1234_5678, 1'b0};
    tv[2] = '{1'b1, 32'hDEAD_BEEF, 1'b1};
    tv[3] = '{1'b0, 32'h0000_00A5, 1'b0};
    tv[4] = '{1'b1, 32'h0000_00A5, 1'b1};
    tv[5] = '{1'b1, 32'h0000_0000, 1'b1};
    tv[6] = '{1'b1, 32'hFFFF_FFFF, 1'b1};
    tv[7] = '{1'b0, 32'h0F0F_0F0F, 1'b0};
    tv[8] = '{1'b0, 32'hFFFF_FFFF, 1'b0};
    tv[9] = '{1'b1, 32'hFFFF_FFFF, 1'b0};
    // reset state, then capture of the held value because last_val clears to zero
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    reset = 1;
    push_word(32'hFFFF_FFFF);
    @(negedge clk);
    check("push_busy", busy, 1);
    check("push_tx_idle", tx, 1);
    @(negedge clk);
    check("latency_tx_low", tx, 0);
    repeat (WORD_CYC - 1) @(negedge clk);
    check("busy_last_cycle", busy, 1);
    @(negedge clk);
    check("busy_drop", busy, 0);
    wait_idle(100);
    check("rst_word_q", exp_q.size(), 0);
    // table: single-word transactions including run gating and unchanged values
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      run = tv[k].run;
      OUTPORTout = tv[k].val;
      if (tv[k].send) push_word(tv[k].val);
      n0 = rx_cnt;
      @(negedge clk);
      check($sformatf("vec%0d_busy", k), busy, tv[k].send);
      wait_idle(WORD_CYC + 50);
      repeat (40) @(negedge clk);
      check($sformatf("vec%0d_bytes", k), rx_cnt - n0, tv[k].send ? BPW : 0);
      check($sformatf("vec%0d_q", k), exp_q.size(), 0);
    end
    // back-to-back words: starts exactly one frame apart across word boundaries
    start_q.delete();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      OUTPORTout = k;
      push_word(k);
    end
    wait_idle(3 * WORD_CYC + 50);
    check("b2b_frames", start_q.size(), 3 * BPW);
    for (int i = 1; i < start_q.size(); i++)
      check($sformatf("b2b_gap%0d", i), start_q[i] - start_q[i-1], 10 * CLK_DIV);
    check("b2b_ovf", overflow, 0);
    check("b2b_q", exp_q.size(), 0);
    // overflow: one word in the shifter, four queued, the sixth dropped
    n0 = rx_cnt;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) check("ovf_before_drop", overflow, 0);
      OUTPORTout = 32'hA1 + k;
      if (k < 5) push_word(32'hA1 + k);
    end
    @(negedge clk);
    check("ovf_set", overflow, 1);
    wait_idle(6 * WORD_CYC + 50);
    check("ovf_bytes", rx_cnt - n0, 5 * BPW);
    check("ovf_q", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);
    // reset during DATA of byte 2: line idles at once, word re-sent from byte 0
    @(negedge clk);
    OUTPORTout = 32'hCAFE_F00D;
    exp_q.push_back(8'hCA);
    exp_q.push_back(8'hFE);
    repeat (2) @(posedge clk);
    repeat (90) @(posedge clk);
    #1 reset = 0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_q", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    reset = 1;
    push_word(32'hCAFE_F00D);
    @(negedge clk);
    check("recapture_busy", busy, 1);
    wait_idle(WORD_CYC + 50);
    check("recapture_q", exp_q.size(), 0);
    check("recapture_ovf", overflow, 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/outport_uart_tx.md
Name: outport_uart_tx

Overview:
Downstream consumer of the processor's output port. Watches OUTPORTout and, each time the value changes while the processor is running, queues the 32-bit word. It then serializes the word over a single UART TX line, 8N1, as 4 bytes. Gives the board/bench a host-visible trace of program output without stalling the CPU.

Parameters:
CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 4, word capacity of the capture FIFO; power of two, min 2

Ports:
clk  input  1  system clock, same clock as the processor
reset  input  1  asynchronous, active-low reset (asserted when 0)
OUTPORTout  input  32  processor output-port register value
run  input  1  processor run flag; captures enabled only while 1
tx  output  1  UART serial line, idle high
busy  output  1  1 while FIFO non-empty or transmitter not IDLE
overflow  output  1  sticky; set when a capture is dropped due to full FIFO

Behaviour:
- Reset (reset==0, async): tx=1, busy=0, overflow=0, last_val=32'h0, FIFO empty, FSM=IDLE, bit/byte/divider counters=0.
- Change detect: at each posedge, if run==1 and OUTPORTout!=last_val → push OUTPORTout, last_val<=OUTPORTout. If run==0 → no push and last_val unchanged, so a change made while halted is captured once run returns to 1.
- A push attempted while the FIFO is full and no pop occurs in the same cycle → word dropped, last_val still updated, overflow<=1. overflow clears only on reset.
- Simultaneous push and pop on a full FIFO → both succeed; count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START: FIFO non-empty. Pop the head word into shift_word in the same edge; byte_idx=0; tx=0 from that edge.
  - START → DATA: after CLK_DIV cycles. Load byte = shift_word[31-8*byte_idx -: 8], bit_idx=0.
  - DATA: drive byte LSB-first, each bit for CLK_DIV cycles. After bit 7 → STOP, tx=1.
  - STOP: held CLK_DIV cycles. Then, if byte_idx<3: byte_idx++, → START. Else: → START with the next popped word if the FIFO is non-empty (no idle gap); otherwise → IDLE.
- Byte order: MSB byte first (bits 31:24, then 23:16, 15:8, 7:0).
- Frame length: 10*CLK_DIV cycles per byte; 40*CLK_DIV cycles per word (no optional byte).
- Latency: word pushed at edge E into an empty FIFO with FSM IDLE → tx falls at edge E+1.
- Divider: counts 0..CLK_DIV-1 and restarts on every state/bit transition. No fractional accumulation.
- busy is registered and updates on the same edge as the FIFO/FSM state.
- Reset mid-frame: tx returns to 1 immediately (async). The partial frame is abandoned and the FIFO is flushed.

Optional Feature:
Macro OUTPORT_UART_NEWLINE_EN.
- Defined: after byte 3 of each word, the FSM sends a fifth 8N1 frame with payload 8'h0A (same START/DATA/STOP path; byte_idx range 0..4). Word time is 50*CLK_DIV.
- Undefined: exactly 4 frames per word; no extra state or logic.

Test Plan:
- Reset: hold reset=0 with OUTPORTout=32'hFFFF_FFFF and run=1; release → tx=1, busy=0, overflow=0. Next cycle pushes 32'hFFFF_FFFF because last_val=0.
- Single word (CLK_DIV=4): OUTPORTout 0→32'h1234_5678, run=1 → tx falls 1 cycle later. Decoded bytes 12,34,56,78; busy drops 160 cycles after the start bit (200 with OUTPORT_UART_NEWLINE_EN, 5th byte 0A).
- Gated by run: run=0, OUTPORTout changes to 32'hA5 → no tx activity. Set run=1 → word 32'h0000_00A5 transmitted once.
- Back-to-back: three changes on consecutive cycles (1, 2, 3) → three words sent with no idle-high gap between the STOP of one word and the START of the next; overflow stays 0.
- Overflow (FIFO_DEPTH=4, CLK_DIV=4): six distinct values on consecutive cycles while a word is in flight → overflow=1. Exactly the first five values are transmitted (1 in shifter + 4 queued); the sixth is dropped.
- Reset mid-frame: assert reset during the DATA state of byte 2 → tx=1 and busy=0 immediately. After release with the same OUTPORTout, the word is re-captured (last_val cleared) and re-sent from byte 0.
